ps2_frame_rx: RTL
=================

Name: ps2_frame_rx

Overview:
PS/2 serial frame receiver that runs in the system clock domain. It synchronises and deglitches the raw kb_clock/kb_data pins, shifts in 11-bit frames, checks start/parity/stop, and emits one validated byte per frame as a single-cycle strobe. It sits directly upstream of the scan-code decoder, which consumes data_out/data_valid and tracks the E0 prefix. The system clock is the only clock; the PS/2 clock is treated purely as data.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on kb_clock and kb_data (minimum 2)
FILTER_LEN, 8, consecutive equal synchronised samples needed before the filtered kb_clock level changes
TIMEOUT_CYCLES, 100000, system cycles allowed between falling edges inside a frame (2 ms at 50 MHz)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
kb_clock  input  1  raw PS/2 clock pin, idles high
kb_data  input  1  raw PS/2 data pin, idles high
data_out  output  8  last valid received byte
data_valid  output  1  one-cycle strobe: data_out updated this cycle
frame_err  output  1  one-cycle strobe: frame discarded
err_type  output  2  reason for discard, held until the next frame_err: 01 parity, 10 stop/start, 11 timeout
rx_busy  output  1  high while a frame is in progress

Behaviour:
- Interface: one clock, `clock`. `reset` is asynchronous and active-high; no other clock or reset.
- Reset values: data_out=0x00, data_valid=0, frame_err=0, err_type=00, rx_busy=0. Synchroniser and filter registers reset to 1 (idle high); state=IDLE; bit counter=0; timeout counter=0.
- Sync: each pin passes through its own chain of SYNC_STAGES flops.
- Filter:
  - filt_clk takes a new value only after FILTER_LEN consecutive synchronised samples of that value.
  - fall = filt_clk goes 1->0 (one-cycle pulse).
  - A low pulse shorter than FILTER_LEN cycles is ignored.
- Sampling: on fall, sample the synchronised kb_data.
- States:
  - IDLE:
    - fall with data 0 -> SHIFT, bit count=1, rx_busy=1.
    - fall with data 1 -> stay IDLE; no error (spurious edge).
  - SHIFT:
    - bits 1..8 fill the data byte LSB first.
    - bit 9 is the parity bit.
    - On bit 10 (the stop bit) -> CHECK.
  - CHECK (one cycle, then IDLE, rx_busy=0):
    - Odd parity: the 8 data bits plus the parity bit must contain an odd number of ones. If this holds and stop=1: data_out<=byte, data_valid=1.
    - Parity wrong -> frame_err=1, err_type=01.
    - Parity right but stop=0 -> frame_err=1, err_type=10.
    - data_out is unchanged on any error.
- Latency: data_valid asserts exactly 2 cycles after the fall that samples the stop bit (one cycle to enter CHECK, one to register outputs). Pin to fall is SYNC_STAGES+FILTER_LEN cycles.
- Timeout:
  - The counter clears on every fall and increments while state is not IDLE.
  - At TIMEOUT_CYCLES: go to IDLE, frame_err=1, err_type=11, rx_busy=0, partial bits discarded.
  - The counter saturates and holds 0 in IDLE.
- Simultaneous events: timeout terminal count and fall in the same cycle -> the fall wins; the bit is accepted and the counter clears.
- Strobes: data_valid and frame_err are never both high and each lasts exactly one cycle.
- Reset mid-frame: immediate return to IDLE with reset values; the next start bit begins a fresh frame.

Test Plan:
(Bench parameters: FILTER_LEN=8, TIMEOUT_CYCLES=2000, PS/2 half-period 200 cycles, data changed mid-high.)
1. Frame 0x75, parity 0, stop 1 -> data_out=0x75, single data_valid pulse 2 cycles after the stop-bit fall, frame_err never high, rx_busy drops with valid.
2. Back-to-back frames E0 (parity 0) then 75 -> two valid strobes in order, data_out 0xE0 then 0x75.
3. Frame 0x75 with parity 1 -> frame_err pulse, err_type=01, data_out holds 0x75 from the prior frame, no data_valid.
4. Start plus 5 bits then kb_clock held high -> after 2000 cycles from the last fall: frame_err, err_type=11, rx_busy=0. A following frame 0x1B (parity 1) decodes to 0x1B.
5. Glitches: 3-cycle low pulses on kb_clock while idle and mid-frame -> no bit counted; a subsequent frame F0 (parity 1) decodes correctly.
6. reset asserted after 4 bits of a frame -> outputs immediately at reset values. Released, then frame 0x1B -> data_out=0x1B, valid.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and deglitches the PS/2 pins, shifts in
// 11-bit frames, checks odd parity and the stop bit, and strobes out one byte
// per good frame or an error code per discarded frame.
module ps2_frame_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic [1:0] err_type,
  output logic       rx_busy
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [FW-1:0]          r_filt_cnt;
  logic                   r_filt_clk;
  logic                   r_filt_d;
  state_t                 r_state;
  logic [3:0]             r_bit_cnt;
  logic [8:0]             r_shift;
  logic                   r_stop;
  logic [TW-1:0]          r_tmo;
  logic [7:0]             r_data_out;
  logic                   r_data_valid;
  logic                   r_frame_err;
  logic [1:0]             r_err_type;
  logic                   r_busy;

  logic w_clk_s;
  logic w_dat_s;
  logic w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_filt_d & ~r_filt_clk;

  // Metastability synchronisers for both pins; idle level is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], kb_clock};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], kb_data};
    end
  end

  // Clock deglitch: level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_filt_cnt <= '0;
      r_filt_clk <= 1'b1;
      r_filt_d   <= 1'b1;
    end else begin
      r_filt_d <= r_filt_clk;
      if (w_clk_s == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_clk <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM with registered outputs; a fall always beats a timeout in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_stop       <= 1'b0;
      r_tmo        <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_type   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_fall && !w_dat_s) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= 4'd1;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_tmo <= '0;
            if (r_bit_cnt == 4'd10) begin
              r_stop  <= w_dat_s;
              r_state <= S_CHECK;
            end else begin
              r_shift   <= {w_dat_s, r_shift[8:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_type  <= 2'b11;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_CHECK: begin
          r_state   <= S_IDLE;
          r_tmo     <= '0;
          r_bit_cnt <= '0;
          r_busy    <= 1'b0;
          if (!(^r_shift)) begin
            r_frame_err <= 1'b1;
            r_err_type  <= 2'b01;
          end else if (!r_stop) begin
            r_frame_err <= 1'b1;
            r_err_type  <= 2'b10;
          end else begin
            r_data_out   <= r_shift[7:0];
            r_data_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign err_type   = r_err_type;
  assign rx_busy    = r_busy;

endmodule
